// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
//   Definitions shared by the UART FIFO blocks: fifo_ctrl, register_file,
//   uart_tx and uart_rx.
//   - FIFO_OP_* : encodings of the {wr, rd} request pair used by the
//                 controller's per-cycle decode.
//   - FIFO_*_DEF: default address width and almost-full/almost-empty levels.
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    // Request decode, bit 1 = wr, bit 0 = rd
    localparam logic [1:0] FIFO_OP_NOP = 2'b00;
    localparam logic [1:0] FIFO_OP_RD  = 2'b01;
    localparam logic [1:0] FIFO_OP_WR  = 2'b10;
    localparam logic [1:0] FIFO_OP_RW  = 2'b11;

    // Default geometry: 8 entries, almost_full at 6, almost_empty at 1
    localparam int FIFO_W_DEF  = 3;
    localparam int FIFO_AF_DEF = 6;
    localparam int FIFO_AE_DEF = 1;

endpackage

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//   Pointer and flag controller for one UART FIFO (TX or RX). Drives an
//   external register_file: wr_en/w_addr on the write side, r_addr on the
//   combinational read side.
//
// Parameters
//   W        address width, depth = 2**W
//   AF_LVL   almost_full  when occupancy >= AF_LVL (1 .. 2**W)
//   AE_LVL   almost_empty when occupancy <= AE_LVL (0 .. 2**W-1)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   wr            in   write request
//   rd            in   read request (pops the entry at r_addr)
//   wr_en         out  write strobe to register_file (write accepted)
//   w_addr        out  write pointer
//   r_addr        out  read pointer
//   full          out  no free entries (registered)
//   empty         out  no valid entries (registered)
//   almost_full   out  occupancy >= AF_LVL (registered)
//   almost_empty  out  occupancy <= AE_LVL (registered)
//   ovf           out  one-cycle pulse, write rejected because full
//   udf           out  one-cycle pulse, read rejected because empty
//   count         out  occupancy 0..2**W, only when FIFO_COUNT_EN is defined
//
// Configuration
//   FIFO_COUNT_EN  defined: count port present. Undefined: port omitted, the
//                  occupancy register still feeds almost_full/almost_empty.
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int W      = FIFO_W_DEF,
    parameter int AF_LVL = FIFO_AF_DEF,
    parameter int AE_LVL = FIFO_AE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic         rd,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         ovf,
    output logic         udf
`ifdef FIFO_COUNT_EN
    ,
    output logic [W:0]   count
`endif
);

    localparam logic [W-1:0] PTR_ONE = (W)'(1);
    localparam logic [W:0]   OCC_ONE = (W+1)'(1);
    localparam logic [W:0]   AF_THR  = (W+1)'(AF_LVL);
    localparam logic [W:0]   AE_THR  = (W+1)'(AE_LVL);

    logic [W-1:0] r_wptr, r_rptr;
    logic [W:0]   r_occ;
    logic         r_full, r_empty, r_af, r_ae, r_ovf, r_udf;

    logic [1:0]   w_op;
    logic [W-1:0] w_wptr_inc, w_rptr_inc;
    logic [W-1:0] w_wptr_nxt, w_rptr_nxt;
    logic [W:0]   w_occ_nxt;
    logic         w_full_nxt, w_empty_nxt, w_ovf_nxt, w_udf_nxt;

    assign w_op       = {wr, rd};
    assign w_wptr_inc = r_wptr + PTR_ONE;
    assign w_rptr_inc = r_rptr + PTR_ONE;

    // A simultaneous read while full frees the slot the write lands in, and
    // the read side is combinational, so the write is stored in that case too.
    assign wr_en = wr & (~r_full | rd);

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_occ_nxt   = r_occ;
        w_full_nxt  = r_full;
        w_empty_nxt = r_empty;
        w_ovf_nxt   = 1'b0;
        w_udf_nxt   = 1'b0;
        case (w_op)
            FIFO_OP_WR: begin
                if (!r_full) begin
                    w_wptr_nxt  = w_wptr_inc;
                    w_occ_nxt   = r_occ + OCC_ONE;
                    w_empty_nxt = 1'b0;
                    w_full_nxt  = (w_wptr_inc == r_rptr);
                end else begin
                    w_ovf_nxt   = 1'b1;
                end
            end
            FIFO_OP_RD: begin
                if (!r_empty) begin
                    w_rptr_nxt  = w_rptr_inc;
                    w_occ_nxt   = r_occ - OCC_ONE;
                    w_full_nxt  = 1'b0;
                    w_empty_nxt = (w_rptr_inc == r_wptr);
                end else begin
                    w_udf_nxt   = 1'b1;
                end
            end
            FIFO_OP_RW: begin
                if (r_empty) begin
                    // Nothing to read yet: no read-through, the write alone lands
                    w_wptr_nxt  = w_wptr_inc;
                    w_occ_nxt   = r_occ + OCC_ONE;
                    w_empty_nxt = 1'b0;
                    w_full_nxt  = (w_wptr_inc == r_rptr);
                    w_udf_nxt   = 1'b1;
                end else begin
                    // Normal or full: both advance, occupancy and flags hold
                    w_wptr_nxt  = w_wptr_inc;
                    w_rptr_nxt  = w_rptr_inc;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_occ   <= w_occ_nxt;
            r_full  <= w_full_nxt;
            r_empty <= w_empty_nxt;
            // Level flags come from next-state occupancy so they move with full/empty
            r_af    <= (w_occ_nxt >= AF_THR);
            r_ae    <= (w_occ_nxt <= AE_THR);
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
        end
    end

    assign w_addr       = r_wptr;
    assign r_addr       = r_rptr;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign ovf          = r_ovf;
    assign udf          = r_udf;
`ifdef FIFO_COUNT_EN
    assign count        = r_occ;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
//   Directed bench for fifo_ctrl (W=3, AF_LVL=6, AE_LVL=1). A behavioural
//   8x8 storage array stands in for register_file; a queue holds the entries
//   that should be in the FIFO. Honours FIFO_COUNT_EN for the count port.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr, rd;
    logic       wr_en;
    logic [2:0] w_addr, r_addr;
    logic       full, empty, almost_full, almost_empty, ovf, udf;
`ifdef FIFO_COUNT_EN
    logic [3:0] count;
`endif

    logic [7:0] w_data;
    logic [7:0] mem [8];
    logic [7:0] r_data;

    logic [7:0] q [$];
    logic [2:0] mw, mr;
    int         n_chk  = 0;
    int         n_pass = 0;

    fifo_ctrl #(.W(3), .AF_LVL(6), .AE_LVL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .rd           (rd),
        .wr_en        (wr_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
`ifdef FIFO_COUNT_EN
        ,
        .count        (count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= w_data;
    end
    assign r_data = mem[r_addr];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // One clock with the given requests; checks the strobe and read data
    // before the edge and every flag/pointer after it against the queue model.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        logic wacc, racc;
        int   occ;
        occ  = q.size();
        racc = r && (occ > 0);
        wacc = w && ((occ < 8) || racc);
        wr = w; rd = r; w_data = d;
        #1;
        chk("wr_en", wr_en, wacc);
        if (racc) chk("r_data", r_data, q[0]);
        @(posedge clk); #1;
        if (racc) begin void'(q.pop_front()); mr = mr + 3'd1; end
        if (wacc) begin q.push_back(d); mw = mw + 3'd1; end
        wr = 1'b0; rd = 1'b0;
        occ = q.size();
        chk("ovf",          ovf,          w && !wacc);
        chk("udf",          udf,          r && !racc);
        chk("w_addr",       w_addr,       mw);
        chk("r_addr",       r_addr,       mr);
        chk("full",         full,         occ == 8);
        chk("empty",        empty,        occ == 0);
        chk("almost_full",  almost_full,  occ >= 6);
        chk("almost_empty", almost_empty, occ <= 1);
`ifdef FIFO_COUNT_EN
        chk("count",        count,        occ);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_w_addr", w_addr, 0);
        chk("rst_r_addr", r_addr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
`ifdef FIFO_COUNT_EN
        chk("rst_count", count, 0);
`endif
        q.delete();
        mw = 3'd0; mr = 3'd0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        mw = 3'd0; mr = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("init_empty", empty, 1);

        // 1: reset in the middle of a run
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i));
        chk("pre_rst_w_addr", w_addr, 3);
        do_reset();

        // 2: fill from empty, then overflow
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'hA0 + 8'(i));
            if (i == 0) chk("empty_after_1st", empty, 0);
            if (i == 4) chk("af_after_5th", almost_full, 0);
            if (i == 5) chk("af_after_6th", almost_full, 1);
            if (i == 6) chk("full_after_7th", full, 0);
            if (i == 7) chk("full_after_8th", full, 1);
        end
        cyc(1'b1, 1'b0, 8'hEE);
        chk("ovf_9th_write", ovf, 1);
        chk("w_addr_9th_write", w_addr, 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_clears", ovf, 0);

        // 3: drain in order, then underflow
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", r_data, 8'hA0 + 8'(i));
            cyc(1'b0, 1'b1, 8'h00);
            if (i == 5) chk("ae_after_6th", almost_empty, 0);
            if (i == 6) chk("ae_after_7th", almost_empty, 1);
            if (i == 6) chk("empty_after_7th", empty, 0);
            if (i == 7) chk("empty_after_8th", empty, 1);
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("udf_9th_read", udf, 1);
        chk("r_addr_9th_read", r_addr, 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("udf_clears", udf, 0);

        // 4: simultaneous wr+rd when empty, then when full
        cyc(1'b1, 1'b1, 8'h55);
        chk("rw_empty_udf", udf, 1);
        chk("rw_empty_empty", empty, 0);
        chk("rw_empty_w_addr", w_addr, 1);
`ifdef FIFO_COUNT_EN
        chk("rw_empty_count", count, 1);
`endif
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i));
        chk("refill_full", full, 1);
        cyc(1'b1, 1'b1, 8'h77);
        chk("rw_full_full", full, 1);
        chk("rw_full_ovf", ovf, 0);
        chk("rw_full_w_addr", w_addr, 1);
        chk("rw_full_r_addr", r_addr, 1);

        // 5: interleaved traffic with pointer wrap, then drain
        for (int i = 0; i < 20; i++)
            cyc(1'b1 && ((i % 4) != 3), 1'b1 && ((i % 3) != 0), 8'h80 + 8'(i));
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("final_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
